// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaler, wrap pulse and a time-multiplexed
// seven-segment scan driver. Per-digit step logic lives in bcd_digit_step.

module bcd_digit_step (
    input  logic [3:0] cur,
    input  logic       step_in,
    input  logic       up,
    output logic [3:0] nxt,
    output logic       step_out
);
    logic at_lim;

    // >= 9 keeps the up path closed even for a nibble that can never be loaded
    assign at_lim   = up ? (cur >= 4'd9) : (cur == 4'd0);
    assign step_out = step_in & at_lim;

    always_comb begin
        nxt = cur;
        if (step_in) begin
            if (at_lim)  nxt = up ? 4'd0 : 4'd9;
            else if (up) nxt = cur + 4'd1;
            else         nxt = cur - 4'd1;
        end
    end
endmodule

module bcd_scan_counter #(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 50,
    parameter int SCAN_DIV       = 4,
    parameter int ACTIVE_LOW_SEG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Din,
    input  logic                  En,
    input  logic                  Up,
    output logic [4*DIGITS-1:0]   Q,
    output logic [7:0]            Q_seg,
    output logic [DIGITS-1:0]     Dig_sel,
    output logic                  Carry
);
    localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIGITS-1:0][3:0] q_r, q_nxt, din_clean;
    logic [DIGITS:0]        step;
    logic [PC_W-1:0]        pc;
    logic [SC_W-1:0]        sc;
    logic [IDX_W-1:0]       idx;
    logic                   carry_r;
    logic                   tick;
    logic                   wrap;
    logic [3:0]             cur_digit;
    logic [7:0]             seg_raw;

    assign tick    = En && (pc == PC_LAST);
    assign step[0] = tick;
    assign wrap    = step[DIGITS];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            bcd_digit_step u_step (
                .cur      (q_r[g]),
                .step_in  (step[g]),
                .up       (Up),
                .nxt      (q_nxt[g]),
                .step_out (step[g+1])
            );
            assign din_clean[g] = (Din[4*g +: 4] > 4'd9) ? 4'd0 : Din[4*g +: 4];
            assign Dig_sel[g]   = (idx == IDX_W'(g));
        end
    endgenerate

    // Count path: Load overrides a coincident tick and restarts the prescaler phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r     <= '0;
            pc      <= '0;
            carry_r <= 1'b0;
        end else if (Load) begin
            q_r     <= din_clean;
            pc      <= '0;
            carry_r <= 1'b0;
        end else begin
            if (En) pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
            q_r     <= q_nxt;
            carry_r <= wrap;
        end
    end

    // Scan path runs independently of Load/En
    always_ff @(posedge clk) begin
        if (!rst) begin
            sc  <= '0;
            idx <= '0;
        end else if (sc == SC_LAST) begin
            sc  <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            sc  <= sc + SC_W'(1);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == IDX_W'(i)) cur_digit = q_r[i];
    end

    always_comb begin
        case (cur_digit)
            4'd0:    seg_raw = 8'h3F;
            4'd1:    seg_raw = 8'h06;
            4'd2:    seg_raw = 8'h5B;
            4'd3:    seg_raw = 8'h4F;
            4'd4:    seg_raw = 8'h66;
            4'd5:    seg_raw = 8'h6D;
            4'd6:    seg_raw = 8'h7D;
            4'd7:    seg_raw = 8'h07;
            4'd8:    seg_raw = 8'h7F;
            4'd9:    seg_raw = 8'h6F;
            default: seg_raw = 8'h00;
        endcase
    end

    assign Q_seg = (ACTIVE_LOW_SEG != 0) ? ~seg_raw : seg_raw;
    assign Q     = q_r;
    assign Carry = carry_r;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: driver pushes expected post-edge outputs from an integer
// reference model; monitor pops and compares after every rising edge.

module tb_bcd_scan_counter;
    localparam int D  = 2;
    localparam int TD = 3;
    localparam int SD = 2;

    logic         clk = 1'b0;
    logic         rst, Load, En, Up;
    logic [7:0]   Din;
    logic [7:0]   Q, Q_seg, Q_al, Q_seg_al;
    logic [1:0]   Dig_sel, Dig_sel_al;
    logic         Carry, Carry_al;

    always #5 clk = ~clk;

    bcd_scan_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .ACTIVE_LOW_SEG(0)) dut (
        .clk(clk), .rst(rst), .Load(Load), .Din(Din), .En(En), .Up(Up),
        .Q(Q), .Q_seg(Q_seg), .Dig_sel(Dig_sel), .Carry(Carry)
    );

    bcd_scan_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .ACTIVE_LOW_SEG(1)) dut_al (
        .clk(clk), .rst(rst), .Load(Load), .Din(Din), .En(En), .Up(Up),
        .Q(Q_al), .Q_seg(Q_seg_al), .Dig_sel(Dig_sel_al), .Carry(Carry_al)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] seg;
        logic [1:0] sel;
        logic       carry;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    bit   done   = 0;

    // reference state: plain integers
    int   m_cnt = 0, m_pc = 0, m_sc = 0, m_idx = 0;
    bit   m_carry = 0;
    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic int digit_of(int v, int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic int sanitize(logic [7:0] d);
        int lo = (d[3:0] > 9) ? 0 : int'(d[3:0]);
        int hi = (d[7:4] > 9) ? 0 : int'(d[7:4]);
        return hi * 10 + lo;
    endfunction

    task automatic model_step(bit r, bit ld, logic [7:0] din, bit en, bit up);
        bit tick;
        exp_t e;
        if (!r) begin
            m_cnt = 0; m_pc = 0; m_sc = 0; m_idx = 0; m_carry = 0;
        end else begin
            tick = en && (m_pc == TD - 1);
            if (m_sc == SD - 1) begin
                m_sc = 0; m_idx = (m_idx + 1) % D;
            end else m_sc++;
            if (ld) begin
                m_cnt = sanitize(din); m_pc = 0; m_carry = 0;
            end else begin
                if (en) m_pc = (m_pc + 1) % TD;
                m_carry = 0;
                if (tick) begin
                    if (up) begin m_carry = (m_cnt == 99); m_cnt = (m_cnt + 1) % 100; end
                    else    begin m_carry = (m_cnt == 0);  m_cnt = (m_cnt + 99) % 100; end
                end
            end
        end
        e.q     = {4'(digit_of(m_cnt, 1)), 4'(digit_of(m_cnt, 0))};
        e.seg   = seg_tab[digit_of(m_cnt, m_idx)];
        e.sel   = 2'(1 << m_idx);
        e.carry = m_carry;
        sb.push_back(e);
    endtask

    task automatic drive(bit r, bit ld, logic [7:0] din, bit en, bit up);
        @(negedge clk);
        rst = r; Load = ld; Din = din; En = en; Up = up;
        model_step(r, ld, din, en, up);
    endtask

    task automatic chk8(string name, logic [7:0] got, logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk8("q",        Q,                 e.q);
            chk8("seg",      Q_seg,             e.seg);
            chk8("dig_sel",  {6'd0, Dig_sel},   {6'd0, e.sel});
            chk8("carry",    {7'd0, Carry},     {7'd0, e.carry});
            chk8("q_al",     Q_al,              e.q);
            chk8("seg_al",   Q_seg_al,          ~e.seg);
            chk8("sel_al",   {6'd0, Dig_sel_al}, {6'd0, e.sel});
            chk8("carry_al", {7'd0, Carry_al},  {7'd0, e.carry});
        end
    end

    initial begin
        rst = 1'b0; Load = 1'b1; En = 1'b1; Up = 1'b1; Din = 8'h55;
        // reset held with Load and En asserted
        drive(0, 1, 8'h55, 1, 1);
        drive(0, 1, 8'h55, 1, 1);
        // load with an invalid low nibble, idle to observe both scan slots
        drive(1, 1, 8'h4A, 0, 1);
        repeat (6) drive(1, 0, 8'h00, 0, 1);
        // up count across all-9s
        drive(1, 1, 8'h98, 0, 1);
        repeat (8) drive(1, 0, 8'h00, 1, 1);
        // down count with borrow and wrap below zero
        drive(1, 1, 8'h10, 0, 0);
        repeat (3) drive(1, 0, 8'h00, 1, 0);
        drive(1, 1, 8'h00, 0, 0);
        repeat (4) drive(1, 0, 8'h00, 1, 0);
        // enable hold mid-phase
        drive(1, 1, 8'h25, 0, 1);
        drive(1, 0, 8'h00, 1, 1);
        repeat (5) drive(1, 0, 8'h00, 0, 1);
        repeat (4) drive(1, 0, 8'h00, 1, 1);
        // load on a tick cycle from all-9s: no carry
        drive(1, 1, 8'h99, 0, 1);
        repeat (2) drive(1, 0, 8'h00, 1, 1);
        drive(1, 1, 8'h99, 1, 1);
        repeat (4) drive(1, 0, 8'h00, 1, 1);
        // mid-count reset
        drive(0, 0, 8'h00, 1, 1);
        // randomized phase, biased toward wrap-prone loads
        for (int i = 0; i < 3000; i++) begin
            bit r, ld, en, up;
            logic [7:0] din;
            r   = ($urandom_range(0, 99) != 0);
            ld  = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       din = 8'h99;
                1:       din = 8'h00;
                default: din = 8'($urandom);
            endcase
            drive(r, ld, din, en, up);
        end
        begin
            int waited = 0;
            while (sb.size() > 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (sb.size() > 0) begin
                n_miss++;
                $display("FAIL drain got=%0d pending exp=0", sb.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
